// File: rtl/vga_scan.sv
// vga_scan: raster scan generator and framebuffer fetch stage for the
// 640x480@60 Hz display path. Owns the h/v fetch counters, issues linear
// framebuffer reads, and delays position/sync/flags by FB_LATENCY cycles so
// they line up with the returned fb_rdata.
//
// Ports:
//   clk_25MHz    pixel clock
//   rst          asynchronous active-low reset
//   scan_en      scan enable; start from park, or stop at frame end
//   pattern_sel  (VGA_PATTERN_EN only) replace framebuffer data by colour bars
//   fb_rd_en     framebuffer read strobe (fetch timing)
//   fb_addr      framebuffer word address, linear row-major (fetch timing)
//   fb_rdata     framebuffer data, FB_LATENCY cycles after fb_rd_en
//   vga_row      aligned horizontal position
//   vga_col      aligned vertical position
//   vga_data     aligned pixel data, 0 outside the visible area
//   vga_hsync    aligned horizontal sync, active-low
//   vga_vsync    aligned vertical sync, active-low
//   vga_active   aligned visible-area flag
//   frame_start  one-cycle pulse on the aligned (0,0) pixel
//
// Optional feature macro: VGA_PATTERN_EN (adds pattern_sel and the 8-bar
// test pattern). Without it vga_data always comes from the framebuffer.

`ifndef VGA_ROW_BUS
`define VGA_ROW_BUS [9:0]
`endif
`ifndef VGA_COL_BUS
`define VGA_COL_BUS [9:0]
`endif
`ifndef VGA_DATA_BUS
`define VGA_DATA_BUS [11:0]
`endif

module vga_scan #(
    parameter int unsigned H_VISIBLE  = 640,
    parameter int unsigned H_FRONT    = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BACK     = 48,
    parameter int unsigned V_VISIBLE  = 480,
    parameter int unsigned V_FRONT    = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BACK     = 33,
    parameter int unsigned FB_LATENCY = 2
) (
    input  logic                 clk_25MHz,
    input  logic                 rst,
    input  logic                 scan_en,
`ifdef VGA_PATTERN_EN
    input  logic                 pattern_sel,
`endif
    output logic                 fb_rd_en,
    output logic [18:0]          fb_addr,
    input  logic `VGA_DATA_BUS   fb_rdata,
    output logic `VGA_ROW_BUS    vga_row,
    output logic `VGA_COL_BUS    vga_col,
    output logic `VGA_DATA_BUS   vga_data,
    output logic                 vga_hsync,
    output logic                 vga_vsync,
    output logic                 vga_active,
    output logic                 frame_start
);

    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HW       = $clog2(H_TOTAL);
    localparam int unsigned VW       = $clog2(V_TOTAL);
    localparam int unsigned HS_FIRST = H_VISIBLE + H_FRONT;
    localparam int unsigned HS_LAST  = HS_FIRST + H_SYNC - 1;
    localparam int unsigned VS_FIRST = V_VISIBLE + V_FRONT;
    localparam int unsigned VS_LAST  = VS_FIRST + V_SYNC - 1;
    localparam int unsigned LAST     = FB_LATENCY - 1;

    typedef logic `VGA_ROW_BUS  row_t;
    typedef logic `VGA_COL_BUS  col_t;
    typedef logic `VGA_DATA_BUS data_t;

    typedef enum logic {
        PARK = 1'b0,
        RUN  = 1'b1
    } state_t;

    // One pixel's worth of position and decoded timing, carried down the delay line.
    typedef struct packed {
        row_t row;
        col_t col;
        logic active;
        logic hsync;
        logic vsync;
        logic first;
    } pix_t;

    localparam pix_t PIX_BLANK = '{row: '0, col: '0, active: 1'b0,
                                   hsync: 1'b1, vsync: 1'b1, first: 1'b0};

    state_t            state, state_nxt;
    logic [HW-1:0]     h, h_nxt;
    logic [VW-1:0]     v, v_nxt;
    logic [18:0]       addr_nxt;
    logic              rd_en_nxt;
    logic              frame_end_c;
    logic              pat_c;
    pix_t              fetch_c;
    pix_t              pipe [FB_LATENCY];

`ifdef VGA_PATTERN_EN
    assign pat_c = pattern_sel;
`else
    assign pat_c = 1'b0;
`endif

    // Next-state, counter advance, address stepping and fetch-position decode.
    always_comb begin
        state_nxt   = state;
        h_nxt       = h;
        v_nxt       = v;
        addr_nxt    = fb_addr;
        fetch_c     = PIX_BLANK;
        frame_end_c = (h == HW'(H_TOTAL - 1)) && (v == VW'(V_TOTAL - 1));

        case (state)
            PARK: begin
                h_nxt = '0;
                v_nxt = '0;
                if (scan_en) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                fetch_c.row    = row_t'(h);
                fetch_c.col    = col_t'(v);
                fetch_c.active = (h < HW'(H_VISIBLE)) && (v < VW'(V_VISIBLE));
                fetch_c.hsync  = !((h >= HW'(HS_FIRST)) && (h <= HW'(HS_LAST)));
                fetch_c.vsync  = !((v >= VW'(VS_FIRST)) && (v <= VW'(VS_LAST)));
                fetch_c.first  = (h == '0) && (v == '0);

                if (h == HW'(H_TOTAL - 1)) begin
                    h_nxt = '0;
                    v_nxt = (v == VW'(V_TOTAL - 1)) ? '0 : v + 1'b1;
                end else begin
                    h_nxt = h + 1'b1;
                end

                // Frame end: address rewinds; stopping is only honoured here.
                if (frame_end_c) begin
                    addr_nxt = '0;
                    if (!scan_en) begin
                        state_nxt = PARK;
                    end
                end else if (fb_rd_en) begin
                    addr_nxt = fb_addr + 1'b1;
                end
            end
            default: begin
                state_nxt = PARK;
            end
        endcase

        // Read strobe registered from the next fetch position so it lines up with h/v.
        rd_en_nxt = (state_nxt == RUN) && (h_nxt < HW'(H_VISIBLE)) &&
                    (v_nxt < VW'(V_VISIBLE)) && !pat_c;
    end

    // State, counters, fetch outputs and the alignment delay line.
    always_ff @(posedge clk_25MHz or negedge rst) begin
        if (!rst) begin
            state    <= PARK;
            h        <= '0;
            v        <= '0;
            fb_addr  <= '0;
            fb_rd_en <= 1'b0;
            for (int i = 0; i < int'(FB_LATENCY); i++) begin
                pipe[i] <= PIX_BLANK;
            end
        end else begin
            state    <= state_nxt;
            h        <= h_nxt;
            v        <= v_nxt;
            fb_addr  <= addr_nxt;
            fb_rd_en <= rd_en_nxt;
            pipe[0]  <= fetch_c;
            for (int i = 1; i < int'(FB_LATENCY); i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign vga_row     = pipe[LAST].row;
    assign vga_col     = pipe[LAST].col;
    assign vga_hsync   = pipe[LAST].hsync;
    assign vga_vsync   = pipe[LAST].vsync;
    assign vga_active  = pipe[LAST].active;
    assign frame_start = pipe[LAST].first;

`ifdef VGA_PATTERN_EN
    logic [2:0] bar_idx_c;
    data_t      bar_c;
    assign bar_idx_c = vga_row[9:7];
    // Each bar index bit drives one colour channel to full scale (R,G,B = bits 2,1,0).
    assign bar_c = data_t'({{4{bar_idx_c[2]}}, {4{bar_idx_c[1]}}, {4{bar_idx_c[0]}}});
`endif

    // fb_rdata arrives in the same cycle as its aligned position, so this mux is combinational.
    always_comb begin
        vga_data = '0;
        if (pipe[LAST].active) begin
            vga_data = fb_rdata;
`ifdef VGA_PATTERN_EN
            if (pattern_sel) begin
                vga_data = bar_c;
            end
`endif
        end
    end

endmodule

// File: tb/tb_vga_scan.sv
// tb_vga_scan: self-checking bench for vga_scan with a reduced raster
// (176x12 totals) so whole frames fit in a short run. A framebuffer stub
// returns the low 12 address bits FB_LATENCY cycles after each read.

module tb_vga_scan;

    localparam int HV = 160;
    localparam int HF = 4;
    localparam int HS = 8;
    localparam int HB = 4;
    localparam int VV = 6;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 2;
    localparam int L  = 2;
    localparam int HT = HV + HF + HS + HB;   // 176
    localparam int VT = VV + VF + VS + VB;   // 12
    localparam int FT = HT * VT;             // 2112
    localparam logic [11:0] GARBAGE = 12'hABC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scan_en = 1'b0;
    logic        pattern_sel = 1'b0;
    logic        fb_rd_en;
    logic [18:0] fb_addr;
    logic [11:0] fb_rdata;
    logic [9:0]  vga_row;
    logic [9:0]  vga_col;
    logic [11:0] vga_data;
    logic        vga_hsync;
    logic        vga_vsync;
    logic        vga_active;
    logic        frame_start;

    int checks = 0;
    int failures = 0;

    always #20 clk = ~clk;

    vga_scan #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .FB_LATENCY(L)
    ) dut (
        .clk_25MHz  (clk),
        .rst        (rst_n),
        .scan_en    (scan_en),
`ifdef VGA_PATTERN_EN
        .pattern_sel(pattern_sel),
`endif
        .fb_rd_en   (fb_rd_en),
        .fb_addr    (fb_addr),
        .fb_rdata   (fb_rdata),
        .vga_row    (vga_row),
        .vga_col    (vga_col),
        .vga_data   (vga_data),
        .vga_hsync  (vga_hsync),
        .vga_vsync  (vga_vsync),
        .vga_active (vga_active),
        .frame_start(frame_start)
    );

    // Framebuffer stub: data = low address bits, garbage when no read was issued.
    logic [11:0] mem_pipe [L];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < L; i++) mem_pipe[i] <= GARBAGE;
        end else begin
            mem_pipe[0] <= fb_rd_en ? fb_addr[11:0] : GARBAGE;
            for (int i = 1; i < L; i++) mem_pipe[i] <= mem_pipe[i-1];
        end
    end
    assign fb_rdata = mem_pipe[L-1];

    // Reference model: the fetch position is a pure function of cycles since start.
    typedef struct {
        int h;
        int v;
        bit act;
        bit hs;
        bit vs;
        bit first;
        bit rd;
        int addr;
    } fet_t;

    fet_t hist [L+1];
    bit   m_run;
    int   m_k;

    function automatic fet_t blank_pix();
        fet_t f;
        f.h = 0; f.v = 0; f.act = 0; f.hs = 1; f.vs = 1; f.first = 0; f.rd = 0; f.addr = 0;
        return f;
    endfunction

    function automatic fet_t fetch_at(input int k, input bit pat);
        fet_t f;
        f.h     = k % HT;
        f.v     = (k / HT) % VT;
        f.act   = (f.h < HV) && (f.v < VV);
        f.rd    = f.act && !pat;
        f.hs    = !((f.h >= HV + HF) && (f.h < HV + HF + HS));
        f.vs    = !((f.v >= VV + VF) && (f.v < VV + VF + VS));
        f.first = (f.h == 0) && (f.v == 0);
        if (pat)          f.addr = 0;
        else if (f.v < VV) f.addr = f.v * HV + ((f.h < HV) ? f.h : HV);
        else              f.addr = HV * VV;
        return f;
    endfunction

    function automatic logic [11:0] bar_of(input int x);
        int idx;
        logic [11:0] d;
        idx = (x >> 7) & 7;
        d = 12'h000;
        if ((idx & 4) != 0) d = d | 12'hF00;
        if ((idx & 2) != 0) d = d | 12'h0F0;
        if ((idx & 1) != 0) d = d | 12'h00F;
        return d;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 1'b0;
            m_k   = 0;
            for (int i = 0; i <= L; i++) hist[i] = blank_pix();
        end else begin
            if (m_run) begin
                if ((m_k % FT) == FT - 1 && !scan_en) m_run = 1'b0;
                else m_k = m_k + 1;
            end else if (scan_en) begin
                m_run = 1'b1;
                m_k   = 0;
            end
            for (int i = L; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = m_run ? fetch_at(m_k, pattern_sel) : blank_pix();
        end
    end

    task automatic chk(input bit ok, input string name, input int act, input int req);
        checks = checks + 1;
        if (!ok) begin
            failures = failures + 1;
            $display("FAIL %s got=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endtask

    // Full-output comparison against the model, at the falling edge.
    task automatic model_cmp();
        fet_t f;
        fet_t a;
        logic [11:0] exp_data;
        f = hist[0];
        a = hist[L];
        exp_data = !a.act ? 12'h000 : (pattern_sel ? bar_of(a.h) : 12'(a.addr));
        checks = checks + 1;
        if (fb_rd_en !== f.rd || fb_addr !== 19'(f.addr) ||
            vga_row !== 10'(a.h) || vga_col !== 10'(a.v) || vga_data !== exp_data ||
            vga_hsync !== a.hs || vga_vsync !== a.vs || vga_active !== a.act ||
            frame_start !== a.first) begin
            failures = failures + 1;
            $display("FAIL model t=%0t got rd=%b addr=%0d row=%0d col=%0d data=%h hs=%b vs=%b act=%b fs=%b required rd=%b addr=%0d row=%0d col=%0d data=%h hs=%b vs=%b act=%b fs=%b",
                     $time, fb_rd_en, fb_addr, vga_row, vga_col, vga_data, vga_hsync,
                     vga_vsync, vga_active, frame_start, f.rd, f.addr, a.h, a.v, exp_data,
                     a.hs, a.vs, a.act, a.first);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        model_cmp();
    endtask

    // Counts falling edges until frame_start, bounded.
    task automatic wait_frame_start(output int n);
        n = 0;
        do begin
            cycle();
            n = n + 1;
        end while (frame_start !== 1'b1 && n < 40);
    endtask

    task automatic wait_pos(input int x, input int y, input string name);
        int n;
        n = 0;
        while (!(int'(vga_row) == x && int'(vga_col) == y) && n < 2 * FT) begin
            cycle();
            n = n + 1;
        end
        chk(int'(vga_row) == x && int'(vga_col) == y, name, n, 2 * FT);
    endtask

    int rd_cnt, hs_cnt, vs_cnt, fs_cnt, hs_bad, vs_bad, max_addr, park_bad, n;
    logic [11:0] d_in1, d_in2, d_out1, d_out2;

    initial begin
        repeat (3) cycle();
        rst_n = 1'b1;
        cycle();
        chk(fb_rd_en == 1'b0 && vga_hsync && vga_vsync && !frame_start && !vga_active &&
            vga_row == 10'd0 && vga_col == 10'd0 && vga_data == 12'h000 && fb_addr == 19'd0,
            "reset_idle", int'(fb_rd_en), 0);

        // Start: first read one cycle later, aligned (0,0) FB_LATENCY cycles after that.
        scan_en = 1'b1;
        cycle();
        chk(fb_rd_en == 1'b1, "first_rd_en", int'(fb_rd_en), 1);
        chk(fb_addr == 19'd0, "first_addr", int'(fb_addr), 0);
        repeat (L) cycle();
        chk(frame_start == 1'b1, "first_frame_start", int'(frame_start), 1);
        chk(vga_row == 10'd0 && vga_col == 10'd0, "first_pos", int'(vga_row) + int'(vga_col), 0);

        // One full frame of statistics.
        rd_cnt = 0; hs_cnt = 0; vs_cnt = 0; fs_cnt = 0; hs_bad = 0; vs_bad = 0; max_addr = 0;
        d_in1 = 12'hFFF; d_in2 = 12'hFFF; d_out1 = 12'hFFF; d_out2 = 12'hFFF;
        for (int i = 0; i < FT; i++) begin
            if (fb_rd_en) begin
                rd_cnt = rd_cnt + 1;
                if (int'(fb_addr) > max_addr) max_addr = int'(fb_addr);
            end
            if (!vga_hsync) begin
                hs_cnt = hs_cnt + 1;
                if (int'(vga_row) < 164 || int'(vga_row) > 171) hs_bad = hs_bad + 1;
            end
            if (!vga_vsync) begin
                vs_cnt = vs_cnt + 1;
                if (int'(vga_col) < 8 || int'(vga_col) > 9) vs_bad = vs_bad + 1;
            end
            if (frame_start) fs_cnt = fs_cnt + 1;
            if (int'(vga_row) == 5   && int'(vga_col) == 2) d_in1  = vga_data;
            if (int'(vga_row) == 130 && int'(vga_col) == 5) d_in2  = vga_data;
            if (int'(vga_row) == 170 && int'(vga_col) == 2) d_out1 = vga_data;
            if (int'(vga_row) == 5   && int'(vga_col) == 7) d_out2 = vga_data;
            cycle();
        end
        chk(rd_cnt == 960, "rd_per_frame", rd_cnt, 960);
        chk(max_addr == 959, "last_addr", max_addr, 959);
        chk(hs_cnt == 96, "hsync_low_cycles", hs_cnt, 96);
        chk(hs_bad == 0, "hsync_position", hs_bad, 0);
        chk(vs_cnt == 352, "vsync_low_cycles", vs_cnt, 352);
        chk(vs_bad == 0, "vsync_position", vs_bad, 0);
        chk(fs_cnt == 1, "frame_start_once", fs_cnt, 1);
        chk(frame_start == 1'b1, "frame_period", int'(frame_start), 1);
        chk(d_in1 == 12'h145, "data_5_2", int'(d_in1), 'h145);
        chk(d_in2 == 12'h3A2, "data_130_5", int'(d_in2), 'h3A2);
        chk(d_out1 == 12'h000, "data_hblank", int'(d_out1), 0);
        chk(d_out2 == 12'h000, "data_vblank", int'(d_out2), 0);

        // Mid-frame drop of scan_en: frame completes, then parks.
        wait_pos(0, 3, "reach_line3");
        scan_en = 1'b0;
        repeat (FT) cycle();
        park_bad = 0;
        for (int i = 0; i < 30; i++) begin
            if (fb_rd_en || !vga_hsync || !vga_vsync || frame_start ||
                vga_row != 10'd0 || vga_col != 10'd0 || fb_addr != 19'd0) park_bad = park_bad + 1;
            cycle();
        end
        chk(park_bad == 0, "parked_idle", park_bad, 0);

        scan_en = 1'b1;
        wait_frame_start(n);
        chk(n == L + 1, "resume_latency", n, L + 1);

        // Asynchronous reset mid-frame.
        wait_pos(30, 2, "reach_30_2");
        #2;
        rst_n = 1'b0;
        scan_en = 1'b0;
        #1;
        chk(!fb_rd_en && fb_addr == 19'd0 && vga_row == 10'd0 && vga_col == 10'd0 &&
            vga_data == 12'h000 && !vga_active && !frame_start && vga_hsync && vga_vsync,
            "async_reset", int'(vga_row), 0);
        repeat (3) cycle();
        rst_n = 1'b1;
        repeat (5) cycle();
        chk(!fb_rd_en && !frame_start && vga_hsync && vga_vsync, "park_after_reset",
            int'(fb_rd_en), 0);

`ifdef VGA_PATTERN_EN
        pattern_sel = 1'b1;
`endif
        scan_en = 1'b1;
        wait_frame_start(n);
        chk(n == L + 1, "restart_latency", n, L + 1);
`ifdef VGA_PATTERN_EN
        wait_pos(128, 0, "reach_128_0");
        chk(vga_data == 12'h00F, "pattern_bar1", int'(vga_data), 'h00F);
        rd_cnt = 0;
        for (int i = 0; i < HT; i++) begin
            if (fb_rd_en) rd_cnt = rd_cnt + 1;
            cycle();
        end
        chk(rd_cnt == 0, "pattern_no_reads", rd_cnt, 0);
`endif
        repeat (FT) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
